hbm_clk_mon: RTL

Simulation-side monitor for the HBM 100 MHz differential reference clock. It consumes `hbm_clk_p`, `hbm_clk_n` and `hbm_clk_locked`, measures the clock frequency against a faster free-running reference clock, and checks that the pair stays complementary. It publishes a qualified `clk_good` status and sticky error flags, so testbenches and HBM bring-up logic can gate traffic on a verified clock.

---
 rtl/hbm_clk_mon.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hbm_clk_mon.sv
// Monitor for the HBM differential reference clock: measures p-leg rising edges per
// reference-clock window, checks the pair stays complementary, and tracks lock loss.
module hbm_clk_mon #(
  parameter int WINDOW_CYCLES   = 1000,
  parameter int EXP_EDGES       = 400,
  parameter int TOL_EDGES       = 8,
  parameter int SETTLE_CYCLES   = 64,
  parameter int DIFF_ERR_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hbm_clk_p,
  input  logic             hbm_clk_n,
  input  logic             hbm_clk_locked,
  input  logic             err_clr,
  output logic             clk_good,
  output logic             meas_valid,
  output logic [CNT_W-1:0] edge_count,
  output logic             freq_err,
  output logic             diff_err,
  output logic             lock_lost,
  output logic [1:0]       state_dbg
);

  localparam int RUN_W = $clog2(DIFF_ERR_CYCLES + 1);
  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXP_LO      = CNT_W'(EXP_EDGES - TOL_EDGES);
  localparam logic [CNT_W-1:0] EXP_HI      = CNT_W'(EXP_EDGES + TOL_EDGES);
  localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(DIFF_ERR_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t state, state_next;

  logic p_m, p_s, p_d, n_m, n_s, lock_m, lock_s;
  logic [CNT_W-1:0] settle_cnt, win_cnt, edge_cnt, edge_next;
  logic [RUN_W-1:0] run_cnt, run_next;
  logic diff_event;
  logic in_settle, in_measure, lock_drop, win_end;
  logic edge_det, diff_hit, in_range, freq_set;

  // All three inputs are asynchronous to clk; p gets one extra stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_m    <= 1'b0;
      p_s    <= 1'b0;
      p_d    <= 1'b0;
      n_m    <= 1'b0;
      n_s    <= 1'b0;
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      p_m    <= hbm_clk_p;
      p_s    <= p_m;
      p_d    <= p_s;
      n_m    <= hbm_clk_n;
      n_s    <= n_m;
      lock_m <= hbm_clk_locked;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (lock_s) state_next = SETTLE;
      SETTLE: begin
        if (!lock_s)                       state_next = IDLE;
        else if (settle_cnt == SETTLE_LAST) state_next = MEASURE;
      end
      MEASURE: if (!lock_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lock loss takes priority over a coinciding window end: the partial result is dropped.
  always_comb begin
    in_settle  = 1'b0;
    in_measure = 1'b0;
    lock_drop  = 1'b0;
    win_end    = 1'b0;
    case (state)
      SETTLE: begin
        in_settle = 1'b1;
        lock_drop = !lock_s;
      end
      MEASURE: begin
        in_measure = 1'b1;
        lock_drop  = !lock_s;
        win_end    = lock_s && (win_cnt == WIN_LAST);
      end
      default: ;
    endcase
    state_dbg = state;
  end

  always_comb begin
    edge_det  = p_s & ~p_d;
    edge_next = (edge_det && (edge_cnt != '1)) ? edge_cnt + 1'b1 : edge_cnt;
    if (p_s == n_s) run_next = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
    else            run_next = '0;
    diff_hit = in_measure && (run_next == RUN_MAX);
    in_range = (edge_next != '0) && (edge_next >= EXP_LO) && (edge_next <= EXP_HI);
    freq_set = win_end && !in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      run_cnt    <= '0;
      diff_event <= 1'b0;
    end else begin
      settle_cnt <= (in_settle && state_next == SETTLE) ? settle_cnt + 1'b1 : '0;
      if (in_measure && !lock_drop) begin
        run_cnt <= run_next;
        if (win_end) begin
          win_cnt    <= '0;
          edge_cnt   <= '0;
          diff_event <= 1'b0;
        end else begin
          win_cnt    <= win_cnt + 1'b1;
          edge_cnt   <= edge_next;
          diff_event <= diff_event | diff_hit;
        end
      end else begin
        win_cnt    <= '0;
        edge_cnt   <= '0;
        run_cnt    <= '0;
        diff_event <= 1'b0;
      end
    end
  end

  // Sticky flags: a new set condition wins over a simultaneous err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_good   <= 1'b0;
      meas_valid <= 1'b0;
      edge_count <= '0;
      freq_err   <= 1'b0;
      diff_err   <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      meas_valid <= win_end;
      if (win_end) begin
        edge_count <= edge_next;
        clk_good   <= in_range && !(diff_event || diff_hit);
      end else if (lock_drop) begin
        clk_good <= 1'b0;
      end
      freq_err  <= freq_set  | (freq_err  & ~err_clr);
      diff_err  <= diff_hit  | (diff_err  & ~err_clr);
      lock_lost <= lock_drop | (lock_lost & ~err_clr);
    end
  end

endmodule
